// File: rtl/frame_ring_buffer.sv
// frame_ring_buffer: N-buffer frame store draining committed frames in order.
// Define FRAME_DROP_EN to drop whole frames when the ring is full, instead of applying backpressure.
module frame_ring_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int NUM_BUFS = 2,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int BUF_WIDTH = $clog2(NUM_BUFS),
    localparam int CNT_WIDTH = $clog2(NUM_BUFS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [WIDTH-1:0]      write_data_i,
    input  logic                  write_valid_i,
    output logic                  write_ready_o,
    output logic [WIDTH-1:0]      read_data_o,
    output logic                  read_valid_o,
    input  logic                  read_ready_i,
    output logic                  read_last_o,
    output logic                  frame_ready_o,
    output logic                  overflow_o,
    output logic [CNT_WIDTH-1:0]  full_count_o,
    output logic [ADDR_WIDTH:0]   write_count_o,
    output logic [ADDR_WIDTH:0]   read_count_o
);
    localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [BUF_WIDTH-1:0] LAST_BUF = BUF_WIDTH'(NUM_BUFS - 1);
    localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(NUM_BUFS);

    logic [WIDTH-1:0] mem [NUM_BUFS*DEPTH];
    logic [BUF_WIDTH-1:0] wr_buf, fetch_buf;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [ADDR_WIDTH:0] write_count, read_count;
    logic [CNT_WIDTH-1:0] full_count, fetch_count;
    logic [WIDTH-1:0] ram_q, skid_q;
    logic ram_v, ram_last, skid_v, skid_last;
    logic wr_fire, wr_last, drop, commit, pop, head_last, free, issue, issue_last;

    assign wr_fire = write_valid_i && write_ready_o;
    assign wr_last = write_count == LAST_CNT;
    assign commit = wr_fire && wr_last && !drop;
    assign read_valid_o = skid_v || ram_v;
    assign read_data_o = skid_v ? skid_q : ram_q;
    assign head_last = skid_v ? skid_last : ram_last;
    assign read_last_o = read_valid_o && head_last;
    assign pop = read_valid_o && read_ready_i;
    assign free = pop && head_last;
    // Fetch runs ahead of the consumer; it stalls only when both stage entries are held.
    assign issue = fetch_count != '0 && !(skid_v && ram_v && !read_ready_i);
    assign issue_last = issue && fetch_addr == LAST_ADDR;
    assign full_count_o = full_count;
    assign write_count_o = write_count;
    assign read_count_o = read_count;

`ifdef FRAME_DROP_EN
    logic drop_q;
    assign write_ready_o = 1'b1;
    // The drop decision is latched at sample 0 and holds for the whole frame.
    assign drop = write_count == '0 ? full_count == FULL : drop_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_q <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            if (wr_fire) drop_q <= drop;
            overflow_o <= wr_fire && wr_last && drop;
        end
    end
`else
    assign write_ready_o = full_count < FULL;
    assign drop = 1'b0;
    assign overflow_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (wr_fire && !drop) mem[{wr_buf, write_count[ADDR_WIDTH-1:0]}] <= write_data_i;
        if (issue) ram_q <= mem[{fetch_buf, fetch_addr}];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_buf <= '0;
            fetch_buf <= '0;
            fetch_addr <= '0;
            write_count <= '0;
            read_count <= '0;
            full_count <= '0;
            fetch_count <= '0;
            frame_ready_o <= 1'b0;
            ram_v <= 1'b0;
            ram_last <= 1'b0;
            skid_v <= 1'b0;
            skid_last <= 1'b0;
            skid_q <= '0;
        end else begin
            if (wr_fire) write_count <= wr_last ? '0 : (ADDR_WIDTH + 1)'(write_count + 1);
            if (commit) wr_buf <= wr_buf == LAST_BUF ? '0 : BUF_WIDTH'(wr_buf + 1);
            full_count <= full_count + CNT_WIDTH'(commit) - CNT_WIDTH'(free);
            fetch_count <= fetch_count + CNT_WIDTH'(commit) - CNT_WIDTH'(issue_last);
            if (issue) fetch_addr <= ADDR_WIDTH'(fetch_addr + 1);
            if (issue) ram_last <= issue_last;
            if (issue_last) fetch_buf <= fetch_buf == LAST_BUF ? '0 : BUF_WIDTH'(fetch_buf + 1);
            if (pop) read_count <= free ? '0 : (ADDR_WIDTH + 1)'(read_count + 1);
            frame_ready_o <= commit;
            skid_v <= skid_v ? (!pop || ram_v) : (ram_v && !pop);
            ram_v <= issue || (skid_v && ram_v && !pop);
            if (ram_v && (skid_v ? pop : !pop)) begin
                skid_q <= ram_q;
                skid_last <= ram_last;
            end
        end
    end
endmodule

// File: tb/tb_frame_ring_buffer.sv
// tb_frame_ring_buffer: randomized and directed bench against a frame-queue reference model.
module tb_frame_ring_buffer;
    localparam int WIDTH = 16, DEPTH = 4, NUM_BUFS = 3;
    localparam int AW = $clog2(DEPTH), CW = $clog2(NUM_BUFS + 1);
`ifdef FRAME_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic clk_i = 1'b0, rst_ni = 1'b1;
    logic [WIDTH-1:0] write_data_i = '0, read_data_o;
    logic write_valid_i = 1'b0, write_ready_o, read_valid_o, read_ready_i = 1'b0;
    logic read_last_o, frame_ready_o, overflow_o;
    logic [CW-1:0] full_count_o;
    logic [AW:0] write_count_o, read_count_o;

    frame_ring_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_BUFS(NUM_BUFS)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .write_data_i(write_data_i), .write_valid_i(write_valid_i), .write_ready_o(write_ready_o),
        .read_data_o(read_data_o), .read_valid_o(read_valid_o), .read_ready_i(read_ready_i),
        .read_last_o(read_last_o), .frame_ready_o(frame_ready_o), .overflow_o(overflow_o),
        .full_count_o(full_count_o), .write_count_o(write_count_o), .read_count_o(read_count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0, n_pass = 0, cyc = 0;
    int exp_q[$], cur[$];
    int m_full = 0, m_wcnt = 0, m_rcnt = 0;
    bit m_drop = 0, track = 0, stalled = 0;
    int t0 = 0, rd_idx = 0;
    logic [WIDTH-1:0] stall_data;
    logic stall_last;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock cycle: check pre-edge outputs, advance the model, check post-edge state.
    task automatic tick();
        bit wr_hs, rd_hs, fr, ov;
        check("write_ready", write_ready_o, DROP || m_full < NUM_BUFS);
        if (m_full == 0) check("valid_before_commit", read_valid_o, 0);
        if (stalled) begin
            check("stall_valid", read_valid_o, 1);
            check("stall_data", read_data_o, stall_data);
            check("stall_last", read_last_o, stall_last);
        end
        wr_hs = write_valid_i && write_ready_o;
        rd_hs = read_valid_o && read_ready_i;
        if (rd_hs) begin
            check("rd_has_frame", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("rd_data", read_data_o, exp_q[0]);
            check("rd_last", read_last_o, m_rcnt == DEPTH - 1);
            if (track) check("rd_cycle", cyc, t0 + 5 + rd_idx);
            rd_idx++;
        end
        stalled = read_valid_o && !read_ready_i;
        stall_data = read_data_o;
        stall_last = read_last_o;
        fr = 0;
        ov = 0;
        if (wr_hs) begin
            if (m_wcnt == 0) m_drop = DROP && m_full == NUM_BUFS;
            if (!m_drop) cur.push_back(int'(write_data_i));
            m_wcnt++;
            if (m_wcnt == DEPTH) begin
                m_wcnt = 0;
                if (m_drop) ov = 1;
                else begin
                    foreach (cur[i]) exp_q.push_back(cur[i]);
                    cur.delete();
                    m_full++;
                    fr = 1;
                end
            end
        end
        if (rd_hs) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            m_rcnt++;
            if (m_rcnt == DEPTH) begin
                m_rcnt = 0;
                m_full--;
            end
        end
        @(posedge clk_i);
        #1;
        cyc++;
        check("frame_ready", frame_ready_o, fr);
        check("overflow", overflow_o, ov);
        check("full_count", full_count_o, m_full);
        check("write_count", write_count_o, m_wcnt);
        check("read_count", read_count_o, m_rcnt);
    endtask

    task automatic do_reset();
        write_valid_i = 0;
        read_ready_i = 0;
        rst_ni = 0;
        #1;
        check("rst_write_ready", write_ready_o, 1);
        check("rst_read_valid", read_valid_o, 0);
        check("rst_read_last", read_last_o, 0);
        check("rst_frame_ready", frame_ready_o, 0);
        check("rst_overflow", overflow_o, 0);
        check("rst_full_count", full_count_o, 0);
        check("rst_write_count", write_count_o, 0);
        check("rst_read_count", read_count_o, 0);
        exp_q.delete();
        cur.delete();
        m_full = 0;
        m_wcnt = 0;
        m_rcnt = 0;
        m_drop = 0;
        stalled = 0;
        track = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1;
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        int n = 0;
        write_valid_i = 1;
        write_data_i = d;
        while (!write_ready_o && n < 50) begin
            tick();
            n++;
        end
        check("send_timeout", n < 50, 1);
        tick();
        write_valid_i = 0;
    endtask

    task automatic drain();
        int n = 0;
        write_valid_i = 0;
        read_ready_i = 1;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2;
        do_reset();
        // Single frame, idle reader: latency and read_last placement.
        read_ready_i = 1;
        track = 1;
        t0 = cyc;
        rd_idx = 0;
        for (int i = 0; i < 4; i++) begin
            write_valid_i = 1;
            write_data_i = WIDTH'(i);
            tick();
        end
        write_valid_i = 0;
        repeat (8) tick();
        check("t1_reads", rd_idx, 4);
        // Fill the ring with the reader stalled, then release.
        do_reset();
        for (int i = 0; i < 12; i++) send(WIDTH'(i));
        write_valid_i = 1;
        write_data_i = WIDTH'(12);
        repeat (3) tick();
        check("t2_full", full_count_o, DROP ? 3 : 3);
        read_ready_i = 1;
        for (int i = 12; i < 16; i++) send(WIDTH'(i));
        drain();
        // Continuous streaming across ten frame boundaries.
        do_reset();
        read_ready_i = 1;
        track = 1;
        t0 = cyc;
        rd_idx = 0;
        for (int i = 0; i < 40; i++) begin
            write_valid_i = 1;
            write_data_i = WIDTH'(i + 'h40);
            tick();
        end
        write_valid_i = 0;
        repeat (10) tick();
        check("t3_reads", rd_idx, 40);
        track = 0;
        // Random valid/ready on both ports.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            write_valid_i = $urandom_range(0, 3) != 0;
            write_data_i = WIDTH'($urandom);
            read_ready_i = $urandom_range(0, 1) == 1;
            tick();
        end
        drain();
        // Reset mid-frame with two frames committed.
        do_reset();
        for (int i = 0; i < 10; i++) send(WIDTH'('h10 + i));
        check("t5_wcnt", write_count_o, 2);
        check("t5_full", full_count_o, 2);
        do_reset();
        read_ready_i = 1;
        track = 1;
        t0 = cyc;
        rd_idx = 0;
        for (int i = 0; i < 4; i++) begin
            write_valid_i = 1;
            write_data_i = WIDTH'('h100 + i);
            tick();
        end
        write_valid_i = 0;
        repeat (8) tick();
        check("t5_reads", rd_idx, 4);
        track = 0;
`ifdef FRAME_DROP_EN
        // One frame more than the ring holds: the last is dropped.
        do_reset();
        for (int i = 0; i < 4 * DEPTH; i++) send(WIDTH'('h200 + i));
        check("t6_full", full_count_o, NUM_BUFS);
        drain();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
